// File: rtl/ram_1r1w_be.sv
// One-read/one-write synchronous RAM with per-byte write enables, selectable
// read-during-write policy and a post-reset clear sequencer.
module ram_1r1w_be #(
  parameter int AW             = 7,
  parameter int DW             = 32,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr,
  input  logic              re,
  output logic [DW-1:0]     rd,
  output logic              rvalid,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wr,
  input  logic [DW/8-1:0]   wmask,
  input  logic              we,
  output logic              ready
);

  localparam int unsigned NB = DW / 8;

  typedef enum logic {CLEAR, IDLE} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_d;
  logic            clr_we;
  logic            acc_re, acc_we, collide;
  logic [DW-1:0]   rd_old, rd_next;
  logic [DW-1:0]   mem [2**AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE:    state_d = IDLE;
      default: state_d = RST_STATE;
    endcase
    // ready is registered, so it rises on the same edge the state enters IDLE
    ready_d = (state_d == IDLE);
  end

  // The registered ready flag doubles as the acceptance gate: it is low
  // throughout CLEAR and asynchronously forced low by rst.
  assign acc_re  = ready & re;
  assign acc_we  = ready & we;
  assign collide = acc_we && (raddr == waddr);
  assign rd_old  = mem[raddr];

  always_comb begin
    rd_next = rd_old;
    if (BYPASS != 0 && collide) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wmask[i]) rd_next[8*i +: 8] = wr[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (acc_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wmask[i]) mem[waddr][8*i +: 8] <= wr[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd     <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= acc_re;
      if (acc_re) rd <= rd_next;
    end
  end

endmodule

// File: doc/ram_1r1w_be.md
# ram_1r1w_be

Parametrised one-read/one-write synchronous RAM, successor to the fixed 128x32 register-file RAM used by the cache and branch-predictor arrays. Adds configurable width and depth, per-byte write enables, and a selectable read-during-write collision policy. Adds a post-reset clear sequencer so tag and valid arrays start zeroed, plus a registered read-valid flag for the consuming pipeline stage.

## Interface
Parameters:
- `AW`, 7, address width; depth is 2^AW entries.
- `DW`, 32, data width; must be a multiple of 8.
- `BYPASS`, 1, collision policy:
  - 1 = write-first: same-cycle write data is forwarded to the read.
  - 0 = read-first: the read returns the old contents.
- `CLEAR_ON_RESET`, 1, when 1, every entry is zeroed after reset before normal operation.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `raddr`  in  AW  read address.
- `re`  in  1  read enable.
- `rd`  out  DW  read data, registered.
- `rvalid`  out  1  high the cycle after an accepted read.
- `waddr`  in  AW  write address.
- `wr`  in  DW  write data.
- `wmask`  in  DW/8  byte write enables; bit i covers `wr[8i+7:8i]`.
- `we`  in  1  write enable.
- `ready`  out  1  high when the RAM accepts reads and writes.

## Operation
- States: `CLEAR` and `IDLE`.
- `rst` asserted (asynchronous):
  - state goes to `CLEAR` if `CLEAR_ON_RESET=1`, else to `IDLE`.
  - clear counter goes to 0.
  - `rd`, `rvalid` and `ready` go to 0.
  - Array contents are not reset directly.
- `CLEAR`:
  - Each cycle, writes all-zero to entry `cnt` with all bytes enabled, then increments `cnt`.
  - When `cnt` = 2^AW-1 is written, moves to `IDLE`.
  - `re` and `we` are ignored, `rvalid`=0, `ready`=0.
- `IDLE`:
  - `ready`=1.
  - Write: when `we`=1, each byte i with `wmask[i]`=1 is updated at the clock edge; bytes with mask 0 keep their value.
  - Write with `wmask`=0: no change.
  - Read: when `re`=1, `rd` is loaded with entry `raddr` at the edge and `rvalid` is 1 in the following cycle.
  - When `re`=0, `rd` holds its previous value and `rvalid` is 0.
- Collision (`re`, `we` both high, `raddr`==`waddr`):
  - `BYPASS=1`: `rd` = per-byte merge. Bytes with `wmask`=1 take `wr`; the others take the old contents.
  - `BYPASS=0`: `rd` = old contents.
  - The write is always performed under either policy.
- Read and write to different addresses in the same cycle are independent.
- `rst` asserted during `CLEAR`: the clear restarts from entry 0 after release.
- `rst` asserted in `IDLE`: array contents are undefined only for a write in flight on that edge; all other entries keep their values.

## Timing
- Read latency: 1 cycle.
  - `re` is sampled at edge N.
  - `rd` and `rvalid` are valid from edge N through edge N+1.
  - `rd` is held afterwards until the next read.
- Write latency: 1 cycle. Data written at edge N is visible to a read sampled at edge N+1 or later, under either policy.
- Clear duration: exactly 2^AW cycles after `rst` deasserts.
  - `ready` rises at edge 2^AW (counting from the first edge with `rst` low).
  - The first transaction is accepted on the edge after `ready` is seen high.
- With `CLEAR_ON_RESET=0`: `ready` rises at the first edge after `rst` deasserts.
- No back-pressure: when `ready`=1, every cycle accepts one read and one write.
- Reset values: `rd`=0, `rvalid`=0, `ready`=0.

## Test plan
- Clear sequence (AW=7, DW=32):
  - Release `rst` → `ready` stays 0 for 128 cycles, then goes high.
  - Reads of addresses 0, 63 and 127 then return 0x00000000, each with `rvalid` one cycle after `re`.
- Byte mask:
  - Write 0xDEADBEEF to address 5 with `wmask`=4'hF.
  - Then write 0x11223344 to address 5 with `wmask`=4'b0101.
  - Read address 5 → 0xDE22BE44.
- Collision, `BYPASS=1`:
  - Address 9 holds 0xAAAAAAAA.
  - In the same cycle, write 0x12345678 with `wmask`=4'b0011 and read address 9 → `rd`=0xAAAA5678.
  - A read in the next cycle also returns 0xAAAA5678.
- Collision, `BYPASS=0`:
  - Same stimulus → `rd`=0xAAAAAAAA.
  - A read in the next cycle returns 0xAAAA5678.
- Hold and rvalid:
  - Read address 5, then drive `re`=0 for 3 cycles → `rd` holds 0xDE22BE44 and `rvalid` is 0 for those cycles.
  - Independent read and write of different addresses in the same cycle both complete.
- Reset mid-clear:
  - Assert `rst` at clear count 50 → `ready`=0 and `rd`=0 immediately, without waiting for a clock edge.
  - After release, `ready` rises exactly 128 cycles later.
  - Requests with `re`/`we` high during `CLEAR` produce no `rvalid` and no array change.
